// File: rtl/emu_step_transactor.sv
// emu_step_transactor: host-driven stimulus/capture transactor with burst clock-enable stepping
module emu_step_transactor #(
    parameter int NUM_STIM = 3,
    parameter int NUM_OUT  = 5,
    parameter int ADDR_W   = 3
) (
    input  logic                  clk_emu,
    input  logic                  rst_emu_n,
    input  logic [7:0]            Din_emu,
    input  logic [ADDR_W-1:0]     Addr_emu,
    input  logic                  wr_emu,
    input  logic                  rd_emu,
    input  logic                  load_emu,
    input  logic                  get_emu,
    input  logic                  run_emu,
    output logic [7:0]            Dout_emu,
    output logic [NUM_STIM*8-1:0] stim_vec,
    input  logic [NUM_OUT*8-1:0]  dut_out,
    output logic                  dut_ce,
    output logic                  busy
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] STIM_LIM = (ADDR_W+1)'(NUM_STIM);
    localparam logic [ADDR_W:0] OUT_LIM  = (ADDR_W+1)'(NUM_OUT);
    typedef enum logic [1:0] {IDLE, RUN, CAP} state_t;
    state_t          state;
    logic [7:0]      cnt;
    logic            done;
    logic            ovf;
    logic [7:0]      stim_sh [DEPTH];
    logic [7:0]      cap [DEPTH];
    logic [ADDR_W:0] addr_x;
    logic            stat_rd;
    logic            any_cmd;
    assign addr_x  = {1'b0, Addr_emu};
    assign stat_rd = rd_emu && addr_x == OUT_LIM;
    assign any_cmd = load_emu | get_emu | run_emu;
    assign busy    = state != IDLE;
    // Host side: shadow writes and registered read-back mux
    always_ff @(posedge clk_emu or negedge rst_emu_n) begin
        if (!rst_emu_n) begin
            for (int i = 0; i < DEPTH; i++) stim_sh[i] <= '0;
            Dout_emu <= '0;
        end else begin
            if (wr_emu && addr_x < STIM_LIM) stim_sh[Addr_emu] <= Din_emu;
            if (rd_emu) Dout_emu <= addr_x < OUT_LIM ? cap[Addr_emu] : stat_rd ? {5'b0, ovf, done, busy} : 8'h00;
        end
    end
    // Burst FSM: command dispatch, clock-enable gating, auto-capture and sticky status
    always_ff @(posedge clk_emu or negedge rst_emu_n) begin
        if (!rst_emu_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dut_ce   <= 1'b0;
            stim_vec <= '0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) cap[i] <= '0;
        end else begin
            if (stat_rd) begin
                done <= 1'b0;
                ovf  <= 1'b0;
            end
            if (busy && any_cmd) ovf <= 1'b1;
            case (state)
                IDLE: begin
                    if (load_emu) begin
                        for (int k = 0; k < NUM_STIM; k++) stim_vec[8*k +: 8] <= stim_sh[k];
                    end else if (get_emu) begin
                        for (int k = 0; k < NUM_OUT; k++) cap[k] <= dut_out[8*k +: 8];
                    end else if (run_emu) begin
                        cnt    <= Din_emu;
                        dut_ce <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == 8'd0) begin
                        dut_ce <= 1'b0;
                        state  <= CAP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                CAP: begin
                    for (int k = 0; k < NUM_OUT; k++) cap[k] <= dut_out[8*k +: 8];
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/emu_step_transactor.md
# emu_step_transactor

Parametrised co-emulation transactor between the host byte link and a DUT. It holds a byte-addressed stimulus shadow array and a capture array, and drives the DUT's clock enable for a host-requested burst of 1..256 cycles. At the end of each burst it auto-captures the DUT outputs and reports status, which removes the host round-trip per DUT clock. It sits between the MCU/FPGA link and any `*_wrapper` DUT, with the DUT clocked from `clk_emu` and gated by `dut_ce`.

## Interface
- `NUM_STIM`, 3: stimulus bytes, 1..2^ADDR_W.
- `NUM_OUT`, 5: capture bytes, 1..2^ADDR_W-1.
- `ADDR_W`, 3: host address width.

- `clk_emu` in 1: the single clock.
- `rst_emu_n` in 1: asynchronous, active-low reset.
- `Din_emu` in 8: host write data; also the burst length for `run_emu`.
- `Addr_emu` in ADDR_W: byte address.
- `wr_emu` in 1: write `Din_emu` to `stim_sh[Addr_emu]`.
- `rd_emu` in 1: read-back strobe.
- `load_emu` in 1: transfer the shadow array to `stim_vec`.
- `get_emu` in 1: manual capture of `dut_out`.
- `run_emu` in 1: start a burst of `Din_emu`+1 DUT cycles.
- `Dout_emu` out 8: read data (registered).
- `stim_vec` out NUM_STIM*8: applied DUT inputs. Byte k is bits [8k+7:8k].
- `dut_out` in NUM_OUT*8: DUT outputs, same packing.
- `dut_ce` out 1: DUT clock enable.
- `busy` out 1: burst or auto-capture in progress.

## Operation
- **FSM states:** IDLE, RUN, CAP.
- **wr_emu:** if `Addr_emu` < NUM_STIM, then `stim_sh[Addr_emu]` <= `Din_emu`. Otherwise ignored. Accepted in any state.
- **rd_emu:** `Dout_emu` <= a value selected by `Addr_emu`. Accepted in any state.
  - `Addr_emu` < NUM_OUT: `cap[Addr_emu]`.
  - `Addr_emu` == NUM_OUT: status = {5'b0, ovf, done, busy}.
  - Any other address: 8'h00.
  - Reading status clears `done` and `ovf`. If a set and this clear happen in the same cycle, the set wins.
- **In IDLE, one of `load_emu`, `get_emu`, `run_emu` is accepted per cycle.** Priority is load > get > run. Lower-priority strobes asserted in the same cycle are dropped silently and do not set `ovf`.
  - **load_emu:** `stim_vec` <= packed `stim_sh`.
  - **get_emu:** `cap[k]` <= `dut_out` byte k, for all k.
  - **run_emu:** `cnt` <= `Din_emu`; go to RUN.
- **RUN:** `dut_ce` = 1.
  - While `cnt` != 0: `cnt` decrements.
  - When `cnt` == 0: go to CAP.
  - Total `dut_ce` high cycles = `Din_emu`+1. `Din_emu` = 0 gives a single step; 255 gives 256 cycles.
- **CAP:** `dut_ce` = 0; `cap` <= `dut_out`; `done` <= 1; go to IDLE.
- **In RUN or CAP, any of `load_emu`/`get_emu`/`run_emu` is ignored** and sets the sticky `ovf`. `stim_vec` never changes mid-burst. `wr_emu` and `rd_emu` remain legal.
- **Reset values:** `stim_sh`, `stim_vec`, `cap`, `Dout_emu` = 0; `dut_ce`, `busy`, `done`, `ovf` = 0; `cnt` = 0; state IDLE.
- **Reset mid-burst:** `dut_ce` falls asynchronously and immediately; no capture occurs.

## Timing
- All outputs are registered, except `busy`, which decodes the state register (high in RUN and CAP).
- **`wr`/`rd`/`load`/`get` latency:** result visible on the cycle after the strobe edge.
- **`run_emu` sampled at edge T:**
  - RUN occupies cycles T+1 .. T+1+N, where N = `Din_emu`. `dut_ce` is high in exactly these cycles.
  - CAP is at cycle T+2+N. `cap` samples `dut_out` at the end of CAP, after the DUT's last enabled edge plus one cycle of settling.
  - `done` = 1 and `busy` = 0 from cycle T+3+N.
- **Back-to-back bursts:** the earliest accepted `run_emu` is in the first IDLE cycle, i.e. edge T+3+N.
- Strobes are level-sampled each edge. A strobe held for multiple cycles repeats its action: a held `run_emu` restarts after each burst.

## Test plan
- **Reset and read-back:** assert `rst_emu_n` low mid-idle -> all outputs 0; status read (Addr=5) returns 8'h00.
- **Write and load:** wr 0xA5, 0x3C, 0x7F to addr 0..2, then load_emu -> `stim_vec` = 24'h7F3CA5 one cycle later. A wr to addr 7 leaves the shadow unchanged.
- **Burst:** run_emu with Din=4 -> `dut_ce` high exactly 5 cycles, `busy` high 6 cycles, then `done` = 1. With `dut_out` driven by a DUT cycle counter, `cap[0]` = 5. Status reads 8'h02, then 8'h00 on re-read.
- **Collision:** during a burst, pulse load_emu and run_emu -> `stim_vec` unchanged, no second burst, status = 8'h06 after the burst.
- **Priority:** in IDLE, assert load_emu, get_emu and run_emu together -> only load occurs, no `dut_ce`, `ovf` = 0.
- **Reset mid-burst:** run_emu with Din=255, assert `rst_emu_n` low at cycle 100 -> `dut_ce` drops without waiting for a clock edge, `cap` = 0, state IDLE after release.
